// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Writer end of the instruction-memory interface. Receives a
//            program as a byte stream (16-bit big-endian word count header
//            followed by big-endian 32-bit words) and writes the words to
//            consecutive word addresses starting at 0. Holds the CPU in reset
//            until a complete, valid image has been loaded.
// Ports    : clk, rst          clock / synchronous active-high reset
//            start             1-cycle load request (honoured in IDLE/DONE/ERR)
//            in_valid/in_data  byte stream in, accepted when in_ready is high
//            in_ready          loader accepts a byte this cycle
//            wr_en/addr/data   imem write port, one strobe per word
//            cpu_hold          active-high reset request to the CPU core
//            busy/done/err     load status levels
//            words_loaded      words written in the current/last load
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HDR_HI = 3'd1;
    localparam logic [2:0] c_ST_HDR_LO = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;
    localparam logic [2:0] c_ST_ERR    = 3'd5;

    // Idle timer only has to reach TIMEOUT-1 before the abort fires.
    localparam int                 c_TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [15:0]         r_count;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_word_buf;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic [ADDR_W:0]     r_words_loaded;
    logic                r_cpu_hold;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_start_ok;
    logic [15:0]         w_hdr_count;
    logic                w_hdr_bad;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_timeout;

    assign w_accept    = in_valid && w_in_ready;
    assign w_start_ok  = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                                   (r_state == c_ST_ERR));
    assign w_hdr_count = {r_count[15:8], in_data};
    assign w_hdr_bad   = (w_hdr_count == 16'd0) || (32'(w_hdr_count) > 32'(DEPTH));
    assign w_word_done = w_accept && (r_state == c_ST_DATA) && (r_byte_idx == 2'd3);
    assign w_last_word = (32'(r_word_idx) == (32'(r_count) - 32'd1));
    // Fires on the TIMEOUT-th consecutive cycle without an accepted byte;
    // in_ready is high in every loading state, so it doubles as "loading".
    assign w_timeout   = (TIMEOUT != 0) && w_in_ready && !w_accept && (r_timer == c_TMR_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (start) w_next_state = c_ST_HDR_HI;
            end
            c_ST_HDR_HI: begin
                if (w_accept)       w_next_state = c_ST_HDR_LO;
                else if (w_timeout) w_next_state = c_ST_ERR;
            end
            c_ST_HDR_LO: begin
                if (w_accept)       w_next_state = w_hdr_bad ? c_ST_ERR : c_ST_DATA;
                else if (w_timeout) w_next_state = c_ST_ERR;
            end
            c_ST_DATA: begin
                if (w_word_done && w_last_word) w_next_state = c_ST_DONE;
                else if (w_timeout)             w_next_state = c_ST_ERR;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            c_ST_HDR_HI, c_ST_HDR_LO, c_ST_DATA: begin
                w_in_ready = 1'b1;
                busy       = 1'b1;
            end
            c_ST_DONE: done = 1'b1;
            c_ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, word assembly, write port, timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= '0;
            r_byte_idx     <= '0;
            r_word_buf     <= '0;
            r_word_idx     <= '0;
            r_timer        <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_words_loaded <= '0;
            r_cpu_hold     <= 1'b1;
        end else begin
            // Write fires the cycle after the 4th byte of a word is taken.
            r_wr_en <= w_word_done;
            if (w_word_done) begin
                r_wr_addr  <= r_word_idx;
                r_wr_data  <= {r_word_buf, in_data};
                r_word_idx <= r_word_idx + ADDR_W'(1);
            end

            if (r_wr_en) r_words_loaded <= r_words_loaded + (ADDR_W + 1)'(1);

            if (w_accept) begin
                case (r_state)
                    c_ST_HDR_HI: r_count[15:8] <= in_data;
                    c_ST_HDR_LO: r_count[7:0]  <= in_data;
                    c_ST_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_word_buf[23:16] <= in_data;
                            2'd1:    r_word_buf[15:8]  <= in_data;
                            2'd2:    r_word_buf[7:0]   <= in_data;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end

            if (w_in_ready) begin
                r_timer <= w_accept ? '0 : (r_timer + c_TMR_W'(1));
            end

            // Release the CPU one cycle after DONE is entered, unless a
            // new load is being requested at the same time.
            r_cpu_hold <= !((r_state == c_ST_DONE) && !start);

            if (w_start_ok) begin
                r_words_loaded <= '0;
                r_byte_idx     <= '0;
                r_word_idx     <= '0;
                r_timer        <= '0;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Scoreboard bench for imem_loader. Stimulus pushes the expected
//            write (address, data, cycle) for every completed word; a monitor
//            pops and compares on each wr_en strobe.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr=%0d data=0x%08h cycle=%0d",
                         wr_addr, wr_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data || cyc != mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL write: got addr=%0d data=0x%08h cycle=%0d expected addr=%0d data=0x%08h cycle=%0d",
                             wr_addr, wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles; returns the cycle stamp
    // visible just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start,
                             output int acc_cyc);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        if (with_start) start = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: in_ready stayed %b for byte 0x%02h", in_ready, b);
            in_valid = 1'b0;
            start    = 1'b0;
            acc_cyc  = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input int addr,
                             input bit start_b0);
        int   c;
        exp_t e;
        send_byte(w[31:24], gap, start_b0, c);
        send_byte(w[23:16], gap, 1'b0, c);
        send_byte(w[15:8],  gap, 1'b0, c);
        send_byte(w[7:0],   gap, 1'b0, c);
        e.addr = ADDR_W'(addr);
        e.data = w;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic send_hdr(input logic [15:0] n, input int gap);
        int c;
        send_byte(n[15:8], gap, 1'b0, c);
        send_byte(n[7:0],  gap, 1'b0, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},     32'(in_ready),     32'd0);
        check({tag, "_wr_en"},        32'(wr_en),        32'd0);
        check({tag, "_wr_addr"},      32'(wr_addr),      32'd0);
        check({tag, "_wr_data"},      wr_data,           32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_err"},          32'(err),          32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        check({tag, "_cpu_hold"},     32'(cpu_hold),     32'd1);
    endtask

    // First DONE cycle: done, not busy, CPU still held; one cycle later
    // the hold drops and the final word count is visible.
    task automatic check_done(input string tag, input int n_words);
        @(negedge clk);
        check({tag, "_done"},      32'(done),     32'd1);
        check({tag, "_busy"},      32'(busy),     32'd0);
        check({tag, "_hold_first"}, 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check({tag, "_hold_next"}, 32'(cpu_hold), 32'd0);
        check({tag, "_words"},     32'(words_loaded), 32'(n_words));
    endtask

    task automatic check_err(input string tag, input int n_words);
        @(negedge clk);
        check({tag, "_err"},      32'(err),          32'd1);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_in_ready"}, 32'(in_ready),     32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_words"},    32'(words_loaded), 32'(n_words));
    endtask

    initial begin
        int c;
        int idle;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic two-word image, back-to-back bytes
        pulse_start();
        send_hdr(16'h0002, 0);
        send_word(32'h20080005, 0, 0, 1'b0);
        send_word(32'h0000000C, 0, 1, 1'b0);
        check_done("basic", 2);

        // Zero-length header
        pulse_start();
        send_hdr(16'h0000, 0);
        check_err("hdr_zero", 0);

        // Header one above DEPTH (1025)
        pulse_start();
        send_hdr(16'h0401, 0);
        check_err("hdr_big", 0);

        // Gapped stream: one byte every 3 cycles, 3 words
        pulse_start();
        send_hdr(16'h0003, 2);
        send_word(32'h3C01DEAD, 2, 0, 1'b0);
        send_word(32'h8C220004, 2, 1, 1'b0);
        send_word(32'hAC230008, 2, 2, 1'b0);
        check_done("gapped", 3);

        // Timeout after 6 data bytes: only word 0 written
        pulse_start();
        send_hdr(16'h0004, 0);
        send_word(32'h11223344, 0, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0, c);
        send_byte(8'h66, 0, 1'b0, c);
        idle = 0;
        while (err !== 1'b1 && idle < 40) begin
            @(negedge clk);
            idle++;
        end
        // 16 full idle cycles, err visible in the following one
        check("timeout_cycles", 32'(idle), 32'd17);
        check("timeout_words",  32'(words_loaded), 32'd1);
        check("timeout_hold",   32'(cpu_hold), 32'd1);
        check("timeout_ready",  32'(in_ready), 32'd0);

        // Reset on the 3rd byte of word 5, then a clean reload
        pulse_start();
        send_hdr(16'h0008, 0);
        for (int i = 0; i < 5; i++) begin
            send_word(32'hA0000000 | 32'(i), 0, i, 1'b0);
        end
        send_byte(8'hB5, 0, 1'b0, c);
        send_byte(8'hC5, 0, 1'b0, c);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hD5;
        rst      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_outputs("midrst");
        rst = 1'b0;
        pulse_start();
        send_hdr(16'h0003, 0);
        send_word(32'h24020001, 0, 0, 1'b0);
        send_word(32'h24030002, 0, 1, 1'b0);
        send_word(32'h00431020, 0, 2, 1'b0);
        check_done("reload", 3);

        // start pulsed during DATA must be ignored
        pulse_start();
        send_hdr(16'h0002, 0);
        send_word(32'hCAFEF00D, 0, 0, 1'b0);
        send_word(32'h0BADBEEF, 0, 1, 1'b1);
        check_done("start_in_data", 2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
